// File: rtl/bmp_stream_buffer_pkg.sv
// Shared constants for the BMP stream buffer.
// FSM encoding, pixel mode codes and frame-size helpers.
package bmp_stream_buffer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_READ  = 2'b01;
    localparam logic [1:0] ST_OPER  = 2'b10;
    localparam logic [1:0] ST_WRITE = 2'b11;

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_INV   = 2'b01;
    localparam logic [1:0] MODE_BIN   = 2'b10;
    localparam logic [1:0] MODE_PASS3 = 2'b11;

    function automatic int bmp_total_size(
        input int hdr,
        input int w,
        input int h,
        input int bpp
    );
        return hdr + w * h * bpp;
    endfunction

    function automatic int bmp_addr_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    localparam int DEF_TOTAL_SIZE = bmp_total_size(54, 4, 4, 3);
    localparam int DEF_ADDR_WIDTH = bmp_addr_width(DEF_TOTAL_SIZE);

endpackage

// File: rtl/bmp_pixel_op.sv
// Combinational per-byte pixel transform.
// Header bytes always pass through untouched.
module bmp_pixel_op
    import bmp_stream_buffer_pkg::*;
#(
    parameter int BYTE_WIDTH = 8,
    parameter int THRESH     = 128
) (
    input  logic [BYTE_WIDTH-1:0] pix_in,
    input  logic [1:0]            mode,
    input  logic                  is_header,
    output logic [BYTE_WIDTH-1:0] pix_out
);

    localparam logic [BYTE_WIDTH-1:0] THR = BYTE_WIDTH'(THRESH);

    // select the transform for pixel bytes
    always_comb begin
        pix_out = pix_in;
        if (!is_header) begin
            unique case (mode)
                MODE_INV:   pix_out = ~pix_in;
                MODE_BIN:   pix_out = (pix_in >= THR) ? '1 : '0;
                MODE_PASS:  pix_out = pix_in;
                MODE_PASS3: pix_out = pix_in;
            endcase
        end
    end

endmodule

// File: rtl/bmp_stream_buffer.sv
// Frame buffer: collect a full BMP byte stream, then replay it
// with an optional pixel transform applied to the image bytes.
module bmp_stream_buffer
    import bmp_stream_buffer_pkg::*;
#(
    parameter int BYTE_WIDTH  = 8,
    parameter int HEADER_SIZE = 54,
    parameter int IMG_W       = 4,
    parameter int IMG_H       = 4,
    parameter int BPP_BYTES   = 3,
    parameter int THRESH      = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic [1:0]            mode,
    output logic                  out_valid,
    output logic [BYTE_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  drop_err
);

    localparam int TOTAL_SIZE =
        bmp_total_size(HEADER_SIZE, IMG_W, IMG_H, BPP_BYTES);
    localparam int ADDR_WIDTH = bmp_addr_width(TOTAL_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(TOTAL_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] HDR_END =
        ADDR_WIDTH'(HEADER_SIZE);

    logic [BYTE_WIDTH-1:0] mem [TOTAL_SIZE];

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [1:0]            mode_q;
    logic                  at_last;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [BYTE_WIDTH-1:0] rd_byte;
    logic [BYTE_WIDTH-1:0] op_byte;

    assign at_last = (count_q == LAST_ADDR);
    assign accept  = in_valid &&
                     ((state_q == ST_IDLE) || (state_q == ST_READ));
    assign wr_addr = (state_q == ST_IDLE) ? '0 : count_q;
    assign rd_byte = mem[count_q];

    bmp_pixel_op #(
        .BYTE_WIDTH (BYTE_WIDTH),
        .THRESH     (THRESH)
    ) u_pixel_op (
        .pix_in    (rd_byte),
        .mode      (mode_q),
        .is_header (count_q < HDR_END),
        .pix_out   (op_byte)
    );

    // next-state decode; unknown encodings fall back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = ST_READ;
            ST_READ:  if (in_valid && at_last) state_d = ST_OPER;
            ST_OPER:  state_d = ST_WRITE;
            ST_WRITE: if (at_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // frame storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (accept) mem[wr_addr] <= in_data;
    end

    // control state, address counter and latched mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            mode_q  <= MODE_PASS;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != ST_IDLE);
            case (state_q)
                ST_IDLE: count_q <= in_valid ? ADDR_WIDTH'(1) : '0;
                ST_READ: begin
                    if (in_valid)
                        count_q <= at_last ? '0 : count_q + 1'b1;
                end
                ST_OPER: begin
                    count_q <= '0;
                    mode_q  <= mode;
                end
                ST_WRITE: count_q <= at_last ? '0 : count_q + 1'b1;
                default:  count_q <= '0;
            endcase
        end
    end

    // registered output stream and sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            out_valid <= (state_q == ST_WRITE);
            out_data  <= (state_q == ST_WRITE) ? op_byte : '0;
            out_last  <= (state_q == ST_WRITE) && at_last;
            if (in_valid &&
                ((state_q == ST_OPER) || (state_q == ST_WRITE)))
                drop_err <= 1'b1;
            else if (in_valid && (state_q == ST_IDLE))
                drop_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bmp_stream_buffer.sv
// Directed bench for bmp_stream_buffer at default parameters.
// Each scenario task drives a frame and checks the replayed stream.
module tb_bmp_stream_buffer;

    localparam int TOT = 102;
    localparam int HDR = 54;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [1:0] mode = 2'b00;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       drop_err;

    logic [7:0] in_b  [TOT];
    logic [7:0] exp_b [TOT];
    logic       drop_first;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    bmp_stream_buffer #(
        .BYTE_WIDTH  (8),
        .HEADER_SIZE (54),
        .IMG_W       (4),
        .IMG_H       (4),
        .BPP_BYTES   (3),
        .THRESH      (128)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .drop_err  (drop_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_byte(
        input int a, input logic [7:0] b, input logic [1:0] m);
        if (a < HDR) return b;
        if (m == 2'b01) return ~b;
        if (m == 2'b10) return (b >= 8'd128) ? 8'hFF : 8'h00;
        return b;
    endfunction

    task automatic load_ramp();
        for (int i = 0; i < TOT; i++) in_b[i] = 8'(i);
    endtask

    task automatic drive_frame(input bit gaps, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            in_valid = 1'b1;
            in_data  = in_b[i];
            step();
            if (i == 0) drop_first = drop_err;
            in_valid = 1'b0;
            in_data  = 8'h00;
            if (gaps && i != nbytes - 1)
                repeat ($urandom_range(1, 3)) step();
        end
    endtask

    // drive a full frame, then check latency and the replayed bytes
    task automatic run_frame(input string name, input logic [1:0] m,
                             input bit gaps, input bit pulse,
                             input bit flip_mode);
        int lat;
        mode = m;
        for (int i = 0; i < TOT; i++) exp_b[i] = ref_byte(i, in_b[i], m);
        drive_frame(gaps, TOT);
        lat = 0;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL %s latency: got %0d want 2", name, lat);
        end
        if (!out_valid) return;
        for (int k = 0; k < TOT; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_b[k] ||
                out_last !== (k == TOT - 1) ||
                (k < TOT - 1 && busy !== 1'b1)) begin
                errors++;
                $display("FAIL %s byte %0d: v=%b d=%h l=%b b=%b want d=%h",
                         name, k, out_valid, out_data, out_last, busy,
                         exp_b[k]);
            end
            if (flip_mode && k == 5) mode = ~m;
            if (pulse && k == 10) begin
                in_valid = 1'b1;
                in_data  = 8'hAA;
            end
            step();
            in_valid = 1'b0;
            in_data  = 8'h00;
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 ||
            out_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s tail: v=%b d=%h l=%b b=%b want all 0",
                     name, out_valid, out_data, out_last, busy);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 ||
            out_last !== 1'b0 || busy !== 1'b0 || drop_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: v=%b d=%h l=%b b=%b e=%b want all 0",
                     out_valid, out_data, out_last, busy, drop_err);
        end
    endtask

    task automatic test_pass();
        load_ramp();
        run_frame("pass", 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_invert();
        for (int i = 0; i < TOT; i++) in_b[i] = (i < HDR) ? 8'h11 : 8'h0F;
        run_frame("invert", 2'b01, 1'b0, 1'b0, 1'b1);
        checks++;
        if (exp_b[HDR] !== 8'hF0 || exp_b[0] !== 8'h11) begin
            errors++;
            $display("FAIL invert table: got %h/%h want 11/F0",
                     exp_b[0], exp_b[HDR]);
        end
    endtask

    task automatic test_binarize();
        for (int i = 0; i < TOT; i++)
            in_b[i] = (i < HDR) ? 8'(i + 100) :
                      ((i % 2) ? 8'd128 : 8'd127);
        run_frame("binarize", 2'b10, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mode11();
        for (int i = 0; i < TOT; i++) in_b[i] = 8'(255 - i);
        run_frame("mode11", 2'b11, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        load_ramp();
        run_frame("gaps", 2'b00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_drop();
        load_ramp();
        run_frame("drop", 2'b00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (drop_err !== 1'b1) begin
            errors++;
            $display("FAIL drop set: got %b want 1", drop_err);
        end
        run_frame("drop_next", 2'b00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (drop_first !== 1'b0 || drop_err !== 1'b0) begin
            errors++;
            $display("FAIL drop clear: first=%b end=%b want 0/0",
                     drop_first, drop_err);
        end
    endtask

    task automatic test_reset_midframe();
        bit seen;
        load_ramp();
        mode = 2'b01;
        drive_frame(1'b0, 60);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 ||
            out_last !== 1'b0 || busy !== 1'b0 || drop_err !== 1'b0) begin
            errors++;
            $display("FAIL midframe reset: v=%b d=%h l=%b b=%b e=%b want 0",
                     out_valid, out_data, out_last, busy, drop_err);
        end
        repeat (3) step();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midframe idle: got activity want none");
        end
        run_frame("after_reset", 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_pass();
        test_invert();
        test_binarize();
        test_mode11();
        test_gaps();
        test_drop();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/bmp_stream_buffer.md
BMP_STREAM_BUFFER -- requirements
Module: bmp_stream_buffer

Interface
REQ-001 Parameter BYTE_WIDTH, default 8, data byte width in bits.
REQ-002 Parameter HEADER_SIZE, default 54, BMP header length in bytes.
REQ-003 Parameter IMG_W, default 4, image width in pixels.
REQ-004 Parameter IMG_H, default 4, image height in pixels.
REQ-005 Parameter BPP_BYTES, default 3, bytes per pixel.
REQ-006 Parameter THRESH, default 128, binarize threshold.
REQ-007 Derived constant TOTAL_SIZE = HEADER_SIZE + IMG_W*IMG_H*BPP_BYTES (102 at defaults); ADDR_WIDTH = clog2(TOTAL_SIZE).
REQ-008 clk  input  1  single clock; all state changes on its rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 in_valid  input  1  in_data carries a valid byte this cycle.
REQ-011 in_data  input  BYTE_WIDTH  input byte stream, file order.
REQ-012 mode  input  2  pixel operation: 00 pass, 01 invert, 10 binarize, 11 pass.
REQ-013 out_valid  output  1  out_data carries a valid byte this cycle (registered).
REQ-014 out_data  output  BYTE_WIDTH  output byte stream, file order (registered).
REQ-015 out_last  output  1  high with the final output byte only (registered).
REQ-016 busy  output  1  high in any state other than IDLE (registered).
REQ-017 drop_err  output  1  sticky flag: in_valid seen while not accepting (registered).

Function
REQ-018 FSM states IDLE, READ, OPERATION, WRITE; any other encoding SHALL go to IDLE.
REQ-019 IDLE: on in_valid, store in_data at address 0, set count=1, go to READ; else stay.
REQ-020 READ: each in_valid cycle stores in_data at address count and increments count; cycles without in_valid hold count (gaps allowed).
REQ-021 READ: when the byte at address TOTAL_SIZE-1 is stored, count SHALL clear to 0 and the next state SHALL be OPERATION.
REQ-022 OPERATION lasts exactly one cycle; mode SHALL be latched in this cycle and held for the whole WRITE phase.
REQ-023 WRITE: out_valid=1 for exactly TOTAL_SIZE consecutive cycles, emitting addresses 0..TOTAL_SIZE-1 in order; then IDLE.
REQ-024 First out_valid SHALL appear 2 cycles after the edge storing the last input byte.
REQ-025 Addresses < HEADER_SIZE SHALL be output unmodified regardless of mode.
REQ-026 Pixel bytes: pass = stored byte; invert = bitwise NOT; binarize = all-ones if byte >= THRESH, else all-zeros (unsigned compare).
REQ-027 out_last SHALL be high exactly on the cycle emitting address TOTAL_SIZE-1.
REQ-028 When out_valid=0, out_data SHALL be 0.
REQ-029 in_valid during OPERATION or WRITE SHALL be ignored (no storage) and SHALL set drop_err.
REQ-030 drop_err clears only on reset or on the IDLE->READ transition.
REQ-031 in_valid on the WRITE->IDLE cycle is ignored; a new frame starts only from IDLE.
REQ-032 Counter SHALL never exceed TOTAL_SIZE-1; no wrap-around inside a phase.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, count 0, latched mode 00, and out_valid, out_data, out_last, busy, drop_err all 0.
REQ-034 Reset mid-frame (any phase) SHALL abort the frame; no further output until a full new frame is received.
REQ-035 Frame memory contents SHALL NOT be reset.

Structure
REQ-036 State encoding, mode encodings and TOTAL_SIZE/ADDR_WIDTH derivation SHALL live in the shared package header.
REQ-037 Pixel transform SHALL be one combinational sub-module bmp_pixel_op (inputs byte, mode, is_header; output byte).
REQ-038 Frame storage SHALL be a single TOTAL_SIZE x BYTE_WIDTH array, one write and one read port.

Verification
REQ-039 Defaults, mode 00, 102 contiguous bytes value=address -> 102 output bytes 0..101 in order, out_last on byte 101, latency 2.
REQ-040 Mode 01, header bytes 0x11, pixel bytes 0x0F -> output 54x 0x11 then 48x 0xF0.
REQ-041 Mode 10, pixel bytes alternating 127/128 -> 0x00/0xFF alternating; header unchanged.
REQ-042 Random 1-3 cycle gaps in in_valid -> output identical to REQ-039, WRITE still 102 contiguous cycles.
REQ-043 in_valid pulsed during WRITE -> drop_err=1, output stream unchanged; clears on next frame start.
REQ-044 rst_n low after 60 input bytes -> all outputs 0, busy 0; next full frame outputs correctly.
